// File: rtl/uart_tx_arbiter_if.sv
// ============================================================================
// Module  : uart_tx_arbiter_if
// Brief   : Requester-side and uart_tx-side signal bundle for uart_tx_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int GW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   ack;
  logic                 err;
  logic                 busy;
  logic [GW-1:0]        grant_id;
  logic                 tx_start;
  logic [7:0]           tx_din;
  logic                 tx_done;

  // master: requesters plus the uart_tx; slave: the arbiter
  modport master (
    output req, req_data, tx_done,
    input  ack, err, busy, grant_id, tx_start, tx_din
  );

  modport slave (
    input  req, req_data, tx_done,
    output ack, err, busy, grant_id, tx_start, tx_din
  );
endinterface

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module  : uart_tx_arbiter
// Brief   : Round-robin arbiter sharing one uart_tx among NUM_REQ requesters,
//           with a tx_done timeout that aborts a stalled transfer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int TIMEOUT_CLKS = 400
) (
  input  wire logic         clk,
  input  wire logic         rstn,
  uart_tx_arbiter_if.slave  bus
);

  localparam int             GW        = $clog2(NUM_REQ);
  localparam logic [GW:0]    c_NUM     = (GW+1)'(NUM_REQ);
  localparam logic [15:0]    c_TO_LAST = 16'(TIMEOUT_CLKS - 1);
  localparam logic [GW-1:0]  c_LAST_RST = GW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [GW-1:0]      r_grant;
  logic [GW-1:0]      r_last;
  logic [7:0]         r_din;
  logic [15:0]        r_cnt;
  logic               r_err;

  logic [GW-1:0]      w_winner;
  logic               w_found;
  logic [GW:0]        w_idx;
  logic [NUM_REQ-1:0] w_ack;
  logic               w_tx_start;
  logic               w_busy;
  logic               w_err;
  logic               w_timeout;
  logic [7:0]         w_bytes [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_bytes[gi] = bus.req_data[8*gi +: 8];
    end
  endgenerate

  // Search starts one past the last winner; one subtraction suffices for wrap
  always_comb begin
    w_winner = '0;
    w_found  = 1'b0;
    w_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = {1'b0, r_last} + (GW+1)'(k + 1);
      if (w_idx >= c_NUM) begin
        w_idx = w_idx - c_NUM;
      end
      if (!w_found && bus.req[w_idx[GW-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_idx[GW-1:0];
      end
    end
  end

  assign w_timeout = (r_cnt == c_TO_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_ack      = '0;
    w_tx_start = 1'b0;
    w_busy     = 1'b1;
    w_err      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (w_found) begin
          w_next = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        w_tx_start = 1'b1;
        w_next     = S_WAIT;
      end
      S_WAIT: begin
        if (bus.tx_done || w_timeout) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_ack[r_grant] = 1'b1;
        w_err          = r_err;
        w_next         = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_grant <= '0;
      r_last  <= c_LAST_RST;
      r_din   <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant <= w_winner;
            r_din   <= w_bytes[w_winner];
          end
        end
        S_LAUNCH: begin
          r_cnt <= '0;
          r_err <= 1'b0;
        end
        S_WAIT: begin
          r_cnt <= r_cnt + 16'd1;
          // tx_done arriving on the timeout cycle still counts as success
          if (!bus.tx_done && w_timeout) begin
            r_err <= 1'b1;
          end
        end
        S_DONE: begin
          r_last <= r_grant;
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.ack      = w_ack;
  assign bus.err      = w_err;
  assign bus.busy     = w_busy;
  assign bus.tx_start = w_tx_start;
  assign bus.grant_id = r_grant;
  assign bus.tx_din   = r_din;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// Module  : tb_uart_tx_arbiter
// Brief   : Directed, table-driven self-checking bench for uart_tx_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int TO = 50;

  logic clk;
  logic rstn;
  int   n_checks;
  int   n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NR)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ      (NR),
    .TIMEOUT_CLKS (TO)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // d: WAIT cycle index at which tx_done is pulsed (>= TO means never)
  // lat: expected WAIT cycle index at which ack is observed
  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    int          d;
    bit          late;
    logic [1:0]  g;
    logic [7:0]  din;
    logic [3:0]  ack;
    logic        err;
    int          lat;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_xfer(input vec_t v, input string nm);
    int         n;
    int         kk;
    bit         stable;
    logic [3:0] a;
    logic       e;
    bus.req      = v.req;
    bus.req_data = v.data;
    bus.tx_done  = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.tx_start !== 1'b1 && n < 20);
    chk({nm, "_start_lat"}, n, 1);
    chk({nm, "_grant"}, bus.grant_id, v.g);
    chk({nm, "_din"}, bus.tx_din, v.din);
    stable = 1'b1;
    a  = '0;
    e  = 1'b0;
    kk = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (k == 0) chk({nm, "_start_1cyc"}, bus.tx_start, 0);
      if (bus.tx_din !== v.din) stable = 1'b0;
      if (bus.ack !== '0) begin
        a  = bus.ack;
        e  = bus.err;
        kk = k;
        break;
      end
      if (v.late && k == 2) begin
        bus.req      = '0;
        bus.req_data = ~v.data;
      end
      bus.tx_done = (k == v.d);
    end
    bus.tx_done = 1'b0;
    chk({nm, "_ack_lat"}, kk, v.lat);
    chk({nm, "_ack"}, a, v.ack);
    chk({nm, "_err"}, e, v.err);
    chk({nm, "_din_stable"}, stable, 1);
    bus.req = '0;
    @(negedge clk);
    chk({nm, "_ack_1cyc"}, bus.ack, 0);
    chk({nm, "_idle"}, bus.busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] exp_b [4];
    int         p;
    int         last_t;
    int         n;
    vec_t       vr;

    tbl[0]  = '{4'b0100, 32'h00A50000, 16,  0, 2'd2, 8'hA5, 4'b0100, 1'b0, 17};
    tbl[1]  = '{4'b1111, 32'hAEABA8A5, 3,   0, 2'd3, 8'hAE, 4'b1000, 1'b0, 4};
    tbl[2]  = '{4'b1111, 32'hAEABA8A5, 0,   0, 2'd0, 8'hA5, 4'b0001, 1'b0, 1};
    tbl[3]  = '{4'b1111, 32'hAEABA8A5, 5,   0, 2'd1, 8'hA8, 4'b0010, 1'b0, 6};
    tbl[4]  = '{4'b1111, 32'hAEABA8A5, 2,   0, 2'd2, 8'hAB, 4'b0100, 1'b0, 3};
    tbl[5]  = '{4'b1111, 32'hAEABA8A5, 1,   0, 2'd3, 8'hAE, 4'b1000, 1'b0, 2};
    tbl[6]  = '{4'b1001, 32'hAEABA8A5, 4,   0, 2'd0, 8'hA5, 4'b0001, 1'b0, 5};
    tbl[7]  = '{4'b1001, 32'hAEABA8A5, 4,   0, 2'd3, 8'hAE, 4'b1000, 1'b0, 5};
    tbl[8]  = '{4'b1001, 32'hAEABA8A5, 4,   0, 2'd0, 8'hA5, 4'b0001, 1'b0, 5};
    tbl[9]  = '{4'b1001, 32'hAEABA8A5, 4,   0, 2'd3, 8'hAE, 4'b1000, 1'b0, 5};
    tbl[10] = '{4'b0010, 32'h00001100, 255, 0, 2'd1, 8'h11, 4'b0010, 1'b1, 50};
    tbl[11] = '{4'b0001, 32'h0000005A, 49,  0, 2'd0, 8'h5A, 4'b0001, 1'b0, 50};
    tbl[12] = '{4'b0001, 32'h0000005A, 48,  0, 2'd0, 8'h5A, 4'b0001, 1'b0, 49};
    tbl[13] = '{4'b0010, 32'h00003C00, 6,   1, 2'd1, 8'h3C, 4'b0010, 1'b0, 7};
    exp_b = '{8'hA5, 8'hA8, 8'hAB, 8'hAE};

    n_checks = 0;
    n_fail   = 0;
    rstn         = 1'b0;
    bus.req      = '0;
    bus.req_data = '0;
    bus.tx_done  = 1'b0;

    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_tx_start", bus.tx_start, 0);
    chk("rst_ack", bus.ack, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_grant", bus.grant_id, 0);
    chk("rst_din", bus.tx_din, 0);
    @(negedge clk);
    rstn = 1'b1;

    // All requesting, tx_done stuck high: it must be ignored outside WAIT
    bus.req      = 4'b1111;
    bus.req_data = 32'hAEABA8A5;
    bus.tx_done  = 1'b1;
    p      = 0;
    last_t = 0;
    for (int t = 1; t <= 40 && p < 4; t++) begin
      @(negedge clk);
      if (bus.tx_start === 1'b1) begin
        chk($sformatf("b2b_grant%0d", p), bus.grant_id, p);
        chk($sformatf("b2b_din%0d", p), bus.tx_din, exp_b[p]);
        chk($sformatf("b2b_gap%0d", p), t - last_t, (p == 0) ? 1 : 4);
        last_t = t;
        p++;
      end
    end
    chk("b2b_pulses", p, 4);
    bus.req = '0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.busy !== 1'b0 && n < 10);
    chk("b2b_drain", bus.busy, 0);
    bus.tx_done = 1'b0;

    for (int i = 0; i < 14; i++) begin
      run_xfer(tbl[i], $sformatf("v%0d", i));
    end

    // Reset 20 cycles into WAIT; arbitration must restart from index 0
    bus.req      = 4'b0100;
    bus.req_data = 32'h00770000;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.tx_start !== 1'b1 && n < 20);
    chk("mid_grant", bus.grant_id, 2);
    repeat (21) @(negedge clk);
    chk("mid_busy_pre", bus.busy, 1);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_tx_start", bus.tx_start, 0);
    chk("mid_rst_ack", bus.ack, 0);
    chk("mid_rst_grant", bus.grant_id, 0);
    chk("mid_rst_din", bus.tx_din, 0);
    bus.req = 4'b1010;
    repeat (2) begin
      @(negedge clk);
      chk("mid_rst_no_ack", bus.ack, 0);
    end
    rstn = 1'b1;
    vr = '{4'b1010, 32'h44332211, 3, 0, 2'd1, 8'h22, 4'b0010, 1'b0, 4};
    run_xfer(vr, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
